// File: rtl/testport_pkg.sv
// Shared definitions for the simulation test-port protocol: default address,
// frame symbols, writer state encoding and the bus byte-order helper.
package testport_pkg;

  localparam logic [29:0] TP_TEST_PORT    = 30'h3FF;
  localparam logic [31:0] TP_BEGIN_SYMBOL = 32'h00000168;
  localparam logic [31:0] TP_END_SYMBOL   = 32'hFFFFFD5D;
  localparam int unsigned TP_MAX_WORDS    = 160;
  localparam int unsigned TP_GAP_CYCLES   = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_BEGIN  = 3'd1,
    ST_GAP       = 3'd2,
    ST_WAIT_WORD = 3'd3,
    ST_WR_WORD   = 3'd4,
    ST_WR_END    = 3'd5,
    ST_DONE      = 3'd6
  } tp_state_e;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/testport_writer.sv
// Streams a framed sequence of result words to the test port as single-word
// bus writes, holding through stalls and forcing a wen-low gap after each write.
module testport_writer
  import testport_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = TP_TEST_PORT,
  parameter logic [31:0] BEGIN_SYMBOL = TP_BEGIN_SYMBOL,
  parameter logic [31:0] END_SYMBOL   = TP_END_SYMBOL,
  parameter int unsigned MAX_WORDS    = TP_MAX_WORDS,
  parameter int unsigned GAP_CYCLES   = TP_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        stall,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
);

  localparam logic [3:0]  GAP_INIT = 4'(GAP_CYCLES - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_WORDS);

  tp_state_e   state_q;
  tp_state_e   ret_q;
  tp_state_e   after_word_d;
  logic [3:0]  gap_q;
  logic        last_q;
  logic        wen_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        done_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] word_count_q;
  logic [15:0] word_count_d;

  // Saturating payload count and the post-gap target once a payload write lands.
  always_comb begin
    word_count_d = word_count_q;
    after_word_d = ST_WAIT_WORD;
    if (word_count_q == MAX_CNT) begin
      word_count_d = word_count_q;
    end else begin
      word_count_d = word_count_q + 16'd1;
    end
    if (last_q || (word_count_d == MAX_CNT)) begin
      after_word_d = ST_WR_END;
    end else begin
      after_word_d = ST_WAIT_WORD;
    end
  end

  // Frame sequencer; every bus-facing output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      gap_q        <= 4'd0;
      last_q       <= 1'b0;
      wen_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= 30'd0;
      data_q       <= 32'd0;
      word_count_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_WR_BEGIN;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            word_count_q <= 16'd0;
            addr_q       <= TEST_PORT;
            data_q       <= byte_swap32(BEGIN_SYMBOL);
            wen_q        <= 1'b1;
          end
        end
        ST_WR_BEGIN, ST_WR_WORD, ST_WR_END: begin
          if (!stall) begin
            wen_q   <= 1'b0;
            state_q <= ST_GAP;
            gap_q   <= GAP_INIT;
            case (state_q)
              ST_WR_BEGIN: ret_q <= ST_WAIT_WORD;
              ST_WR_WORD: begin
                ret_q        <= after_word_d;
                word_count_q <= word_count_d;
              end
              default: ret_q <= ST_DONE;
            endcase
          end
        end
        ST_GAP: begin
          // addr and data stay put through the gap; only wen is low here
          if (gap_q == 4'd0) begin
            state_q <= ret_q;
            case (ret_q)
              ST_WAIT_WORD: in_ready_q <= 1'b1;
              ST_WR_END: begin
                wen_q  <= 1'b1;
                data_q <= byte_swap32(END_SYMBOL);
              end
              ST_DONE: begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
              default: state_q <= ST_IDLE;
            endcase
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        ST_WAIT_WORD: begin
          if (in_valid) begin
            data_q     <= byte_swap32(in_data);
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            wen_q      <= 1'b1;
            state_q    <= ST_WR_WORD;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          wen_q      <= 1'b0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign wen        = wen_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_testport_writer.sv
// Randomized frame bench: two writer instances (default gap/limit and a
// 3-cycle gap with a small limit) checked against a frame-level reference.
module tb_testport_writer;

  localparam int MAXW0 = 160;
  localparam int MAXW1 = 4;
  localparam int GAP0  = 1;
  localparam int GAP1  = 3;
  localparam int BUDGET = 8000;
  localparam logic [31:0] BEGIN_W = 32'h00000168;
  localparam logic [31:0] END_W   = 32'hFFFFFD5D;
  localparam logic [29:0] PORT_A  = 30'h3FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s[2], start_s[2], in_valid_s[2], in_last_s[2], stall_s[2];
  logic [31:0] in_data_s[2];
  logic        in_ready_s[2], wen_s[2], busy_s[2], done_s[2];
  logic [29:0] addr_s[2];
  logic [31:0] data_s[2];
  logic [15:0] word_count_s[2];

  int total = 0;
  int bad   = 0;

  testport_writer #(.MAX_WORDS(MAXW0), .GAP_CYCLES(GAP0)) dut0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_data(in_data_s[0]), .in_last(in_last_s[0]), .in_ready(in_ready_s[0]),
    .stall(stall_s[0]), .addr(addr_s[0]), .data(data_s[0]), .wen(wen_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .word_count(word_count_s[0]));

  testport_writer #(.MAX_WORDS(MAXW1), .GAP_CYCLES(GAP1)) dut1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_data(in_data_s[1]), .in_last(in_last_s[1]), .in_ready(in_ready_s[1]),
    .stall(stall_s[1]), .addr(addr_s[1]), .data(data_s[1]), .wen(wen_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .word_count(word_count_s[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    ref_swap = {<<8{w}};
  endfunction

  task automatic check_idle_outputs(input int sel, input string tag);
    check({tag, "_wen"}, 64'(wen_s[sel]), 64'd0);
    check({tag, "_addr"}, 64'(addr_s[sel]), 64'd0);
    check({tag, "_data"}, 64'(data_s[sel]), 64'd0);
    check({tag, "_rdy"}, 64'(in_ready_s[sel]), 64'd0);
    check({tag, "_busy"}, 64'(busy_s[sel]), 64'd0);
    check({tag, "_done"}, 64'(done_s[sel]), 64'd0);
    check({tag, "_cnt"}, 64'(word_count_s[sel]), 64'd0);
  endtask

  // One complete frame: drive random payload/stalls, collect completed writes,
  // then compare against the frame the protocol rules say must appear.
  task automatic run_frame(input int sel, input int nwords, input int last_idx,
                           input logic [31:0] w0, input int stall_pct,
                           input int valid_pct, input bit poke_start, input string tag);
    logic [31:0] words[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [29:0] h_addr;
    logic [31:0] h_data, lat_data;
    int maxw, gapc, plen, wptr, acc, low_run, min_low, viol, cyc, n;
    bit prev_wen, prev_cmpl, have_write, hold_pend, lat_pend, hs;
    maxw = (sel == 0) ? MAXW0 : MAXW1;
    gapc = (sel == 0) ? GAP0 : GAP1;
    words.push_back(w0);
    for (int i = 1; i < nwords; i++) words.push_back($urandom);
    plen = (last_idx >= 0 && last_idx < maxw) ? last_idx + 1 : maxw;
    exp_q.push_back(ref_swap(BEGIN_W));
    for (int i = 0; i < plen; i++) exp_q.push_back(ref_swap(words[i]));
    exp_q.push_back(ref_swap(END_W));
    wptr = 0; acc = 0; low_run = 0; min_low = 1000; viol = 0; cyc = 0;
    prev_wen = 1'b0; prev_cmpl = 1'b0; have_write = 1'b0; hold_pend = 1'b0; lat_pend = 1'b0;
    h_addr = 30'd0; h_data = 32'd0; lat_data = 32'd0;

    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    start_s[sel] = 1'b0;
    while (!done_s[sel] && cyc < BUDGET) begin
      stall_s[sel]    = ($urandom_range(99) < stall_pct);
      in_valid_s[sel] = (wptr < nwords) && ($urandom_range(99) < valid_pct);
      if (wptr < nwords) in_data_s[sel] = words[wptr];
      else in_data_s[sel] = 32'd0;
      in_last_s[sel]  = (wptr == last_idx);
      start_s[sel]    = poke_start && (cyc == 6);
      @(negedge clk);
      if (lat_pend && !(wen_s[sel] && data_s[sel] == lat_data)) viol++;
      lat_pend = 1'b0;
      if (hold_pend && !(wen_s[sel] && addr_s[sel] == h_addr && data_s[sel] == h_data)) viol++;
      hold_pend = 1'b0;
      if (in_ready_s[sel] && wen_s[sel]) viol++;
      if (wen_s[sel] && prev_cmpl) viol++;
      if (wen_s[sel] && !prev_wen && have_write && low_run < min_low) min_low = low_run;
      if (!wen_s[sel]) begin
        low_run++;
        prev_cmpl = 1'b0;
      end else if (stall_s[sel]) begin
        hold_pend = 1'b1; h_addr = addr_s[sel]; h_data = data_s[sel];
        prev_cmpl = 1'b0;
      end else begin
        got_q.push_back(data_s[sel]);
        if (addr_s[sel] != PORT_A) viol++;
        have_write = 1'b1; low_run = 0; prev_cmpl = 1'b1;
      end
      prev_wen = wen_s[sel];
      hs = in_valid_s[sel] && in_ready_s[sel];
      @(posedge clk); #1;
      if (hs) begin
        lat_data = ref_swap(words[wptr]);
        lat_pend = 1'b1;
        wptr++; acc++;
      end
      cyc++;
    end
    check({tag, "_timeout"}, 64'(cyc < BUDGET), 64'd1);

    // after close: leftover words stay unaccepted and the bus stays quiet
    for (int k = 0; k < 5; k++) begin
      in_valid_s[sel] = (wptr < nwords);
      stall_s[sel] = $urandom_range(1);
      start_s[sel] = 1'b0;
      @(negedge clk);
      if (in_ready_s[sel] || wen_s[sel] || !done_s[sel] || busy_s[sel]) viol++;
      @(posedge clk); #1;
    end
    in_valid_s[sel] = 1'b0; in_last_s[sel] = 1'b0; stall_s[sel] = 1'b0;

    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, "_count"}, 64'(word_count_s[sel]), 64'(plen));
    check({tag, "_accepted"}, 64'(acc), 64'(plen));
    check({tag, "_mingap"}, 64'(min_low), 64'(gapc));
    check({tag, "_protocol"}, 64'(viol), 64'd0);
  endtask

  // Abort a frame while a payload write is on the bus and check the clean restart state.
  task automatic reset_mid(input int sel, input string tag);
    int cyc;
    bit hs;
    cyc = 0; hs = 1'b0;
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    start_s[sel] = 1'b0;
    in_data_s[sel] = $urandom;
    in_valid_s[sel] = 1'b1;
    while (!hs && cyc < 100) begin
      @(negedge clk);
      hs = in_ready_s[sel];
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_s[sel] = 1'b0;
    stall_s[sel] = 1'b1;
    @(negedge clk);
    check({tag, "_wen_before"}, 64'(wen_s[sel]), 64'd1);
    @(posedge clk); #1;
    rst_s[sel] = 1'b1;
    @(posedge clk); #1;
    rst_s[sel] = 1'b0;
    stall_s[sel] = 1'b0;
    @(negedge clk);
    check_idle_outputs(sel, tag);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b1; start_s[s] = 1'b0; in_valid_s[s] = 1'b0;
      in_last_s[s] = 1'b0; stall_s[s] = 1'b0; in_data_s[s] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");
    @(posedge clk); #1;

    run_frame(0, 1, 0, 32'd5, 0, 100, 1'b0, "single");
    run_frame(0, 3, 1, 32'd4184, 60, 100, 1'b0, "stall");
    run_frame(0, 6, 5, $urandom, 10, 8, 1'b0, "backpres");
    run_frame(0, 161, -1, $urandom, 20, 80, 1'b0, "limit");
    run_frame(0, 160, 159, $urandom, 10, 90, 1'b0, "lastmax");
    reset_mid(0, "midrst");
    run_frame(0, 4, 3, $urandom, 20, 70, 1'b0, "afterrst");
    run_frame(1, 3, 2, $urandom, 20, 70, 1'b1, "gap3");
    run_frame(1, 5, -1, $urandom, 30, 60, 1'b1, "gap3lim");
    run_frame(1, 4, 3, $urandom, 0, 100, 1'b0, "gap3lastmax");
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = $urandom_range(1, 12);
      run_frame(r % 2, nw, nw - 1, $urandom, $urandom_range(50), $urandom_range(30, 100),
                1'(r % 2), $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
